// File: rtl/sig_acc.sv
// ============================================================================
// sig_acc -- signed frame accumulator for the SIG multiplier datapath
//
// Purpose:
//   Sums N signed DW-bit products into one AW-bit signed frame sum. Products
//   are accepted with a valid/ready handshake while accumulating (ACC).
//   After the Nth product the sum is registered and presented downstream
//   (HOLD) until the consumer accepts it. Then the next frame starts.
//   iClear aborts the current frame. iRst has priority over everything.
//
// Optional feature (compile-time macro):
//   SIG_ACC_SAT_EN -- when defined, the frame sum is clamped to the DW-bit
//                     signed range [-2^(DW-1), 2^(DW-1)-1], sign-extended to
//                     AW bits. oSat flags frames that were clamped. When the
//                     macro is undefined, the full-precision sum is output
//                     and oSat is constantly 0.
//
// Parameters:
//   DW  width of each signed input product
//   N   products per frame (power of two, 2..256)
//   AW  signed sum width, DW + log2(N); it cannot overflow for any N inputs
//
// Ports:
//   iClk    in   1   clock, all state changes on the rising edge
//   iRst    in   1   synchronous active-high reset
//   iClear  in   1   synchronous abort of the current frame
//   iY      in   DW  signed product from upstream
//   iValid  in   1   iY valid this cycle
//   oReady  out  1   block accepts iY this cycle (ACC state)
//   oSum    out  AW  signed frame sum
//   oValid  out  1   oSum valid (HOLD state)
//   iReady  in   1   downstream accepts oSum
//   oSat    out  1   oSum was clamped (SIG_ACC_SAT_EN builds only)
// ============================================================================
module sig_acc #(
    parameter int DW = 8,
    parameter int N  = 16,
    parameter int AW = DW + $clog2(N)
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iClear,
    input  logic [DW-1:0] iY,
    input  logic          iValid,
    output logic          oReady,
    output logic [AW-1:0] oSum,
    output logic          oValid,
    input  logic          iReady,
    output logic          oSat
);

    localparam int CW = $clog2(N);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q,   acc_d;
    logic        [CW-1:0]  cnt_q,   cnt_d;
    logic signed [AW-1:0]  sum_q,   sum_d;
    logic                  sat_q,   sat_d;

    logic signed [AW-1:0]  y_ext;
    logic signed [AW-1:0]  acc_nxt;
    logic signed [AW-1:0]  sum_out;
    logic                  sat_out;
    logic                  last;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // AW exceeds DW by log2(N) >= 1 bits, so the sign extension is never empty.
    assign y_ext   = {{(AW-DW){iY[DW-1]}}, iY};
    assign acc_nxt = acc_q + y_ext;
    assign last    = (cnt_q == CW'(N - 1));

`ifdef SIG_ACC_SAT_EN
    // Clamp bounds: the DW-bit signed extremes sign-extended to AW bits.
    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        sum_out = acc_nxt;
        sat_out = 1'b0;
        if (acc_nxt > SAT_HI) begin
            sum_out = SAT_HI;
            sat_out = 1'b1;
        end else if (acc_nxt < SAT_LO) begin
            sum_out = SAT_LO;
            sat_out = 1'b1;
        end
    end
`else
    // Full precision. sat_q can only ever load 0, so oSat is constant 0.
    assign sum_out = acc_nxt;
    assign sat_out = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch in this combinational block.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sat_d   = sat_q;

        if (iClear) begin
            // Abort wins over a product or output handshake in the same cycle.
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_ACC: begin
                    if (iValid) begin
                        acc_d = acc_nxt;
                        // The counter is exactly log2(N) bits wide, so the
                        // increment after product N-1 wraps to 0.
                        cnt_d = cnt_q + 1'b1;
                        if (last) begin
                            sum_d   = sum_out;
                            sat_d   = sat_out;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // iValid is ignored here; upstream keeps it asserted.
                    if (iReady) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oReady = (state_q == ST_ACC);
    assign oValid = (state_q == ST_HOLD);
    assign oSum   = sum_q;
    assign oSat   = sat_q;

    // The presented sum must not move while the consumer stalls it.
    a_hold_stable : assert property (
        @(posedge iClk) disable iff (iRst)
        (state_q == ST_HOLD && !iReady && !iClear) |=> ($stable(sum_q) && $stable(sat_q))
    );

endmodule
